// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch sequencer and its PC counter.
package fetch_pkg;

    localparam int unsigned FETCH_ADDR_W   = 12;
    localparam int unsigned FETCH_DATA_W   = 16;
    localparam logic [11:0] FETCH_RESET_PC = 12'h000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        REQ  = 2'd2,
        HOLD = 2'd3
    } state_t;

endpackage

// File: rtl/fetch_sequencer_pc_counter.sv
// Program counter register: reset value, branch load, and increment that wraps at 2^ADDR_W.
module pc_counter
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = FETCH_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] load_val,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_next_c
);

    // Load wins over increment; the increment wraps naturally at the register width.
    always_comb begin
        pc_next_c = pc;
        if (load) begin
            pc_next_c = load_val;
        end else if (inc) begin
            pc_next_c = pc + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next_c;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// PC / instruction-fetch sequencer feeding the MA stage, with req/ack memory reads and valid/ready handoff.
// Optional fetch timeout is enabled by defining FETCH_TIMEOUT_EN.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = FETCH_ADDR_W,
    parameter int unsigned       DATA_W   = FETCH_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC)
`ifdef FETCH_TIMEOUT_EN
    ,
    parameter int unsigned       TIMEOUT_CYC = 15
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              halt,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_addr,
    output logic [ADDR_W-1:0] ma_addr,
    output logic              ma_enable,
    output logic              mem_rd_req,
    input  logic              mem_rd_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] ir_out,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic [ADDR_W-1:0] pc_out,
    output logic              fetch_err
);

    state_t              state_q;
    state_t              state_d;
    logic                discard;
    logic                discard_d;
    logic [DATA_W-1:0]   ir_out_d;
    logic                ir_valid_d;
    logic                req_d;
    logic                ma_enable_d;
    logic [ADDR_W-1:0]   ma_addr_d;
    logic                pc_load;
    logic                pc_inc;
    logic [ADDR_W-1:0]   pc_next_c;
    logic                timeout_c;

    pc_counter #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk       (clk),
        .reset     (reset),
        .load      (pc_load),
        .inc       (pc_inc),
        .load_val  (br_addr),
        .pc        (pc_out),
        .pc_next_c (pc_next_c)
    );

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] req_cnt;

    assign timeout_c = (state_q == REQ) && !mem_rd_ack && (req_cnt == CNT_W'(TIMEOUT_CYC - 1));

    // Counts cycles spent in REQ; zero whenever outside it, so every REQ entry starts from zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_cnt   <= '0;
            fetch_err <= 1'b0;
        end else begin
            req_cnt <= (state_q == REQ) ? req_cnt + CNT_W'(1) : '0;
            if (timeout_c) begin
                fetch_err <= 1'b1;
            end
        end
    end
`else
    assign timeout_c = 1'b0;
    assign fetch_err = 1'b0;
`endif

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ma_addr    <= RESET_PC;
            ma_enable  <= 1'b0;
            mem_rd_req <= 1'b0;
            ir_out     <= '0;
            ir_valid   <= 1'b0;
            discard    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ma_addr    <= ma_addr_d;
            ma_enable  <= ma_enable_d;
            mem_rd_req <= req_d;
            ir_out     <= ir_out_d;
            ir_valid   <= ir_valid_d;
            discard    <= discard_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start && !halt) begin
                    state_d = ADDR;
                end
            end
            ADDR: begin
                state_d = br_valid ? ADDR : REQ;
            end
            REQ: begin
                if (mem_rd_ack) begin
                    state_d = (discard || br_valid) ? ADDR : HOLD;
                end else if (timeout_c) begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (ir_ready) begin
                    state_d = halt ? IDLE : ADDR;
                end else if (br_valid) begin
                    state_d = ADDR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The MA strobe fires on every entry into ADDR, carrying the PC that will be current there.
    assign ma_enable_d = (state_d == ADDR);
    assign ma_addr_d   = (state_d == ADDR) ? pc_next_c : ma_addr;

    // Output / datapath next values.
    always_comb begin
        ir_out_d   = ir_out;
        ir_valid_d = ir_valid;
        discard_d  = discard;
        pc_load    = 1'b0;
        pc_inc     = 1'b0;
        req_d      = (state_d == REQ);
        case (state_q)
            ADDR: begin
                pc_load = br_valid;
            end
            REQ: begin
                pc_load = br_valid;
                if (mem_rd_ack) begin
                    discard_d = 1'b0;
                    if (!discard && !br_valid) begin
                        ir_out_d   = mem_rdata;
                        ir_valid_d = 1'b1;
                    end
                end else if (timeout_c) begin
                    discard_d = 1'b0;
                end else if (br_valid) begin
                    discard_d = 1'b1;
                end
            end
            HOLD: begin
                if (ir_ready) begin
                    ir_valid_d = 1'b0;
                    pc_load    = br_valid;
                    pc_inc     = !br_valid;
                end else if (br_valid) begin
                    pc_load    = 1'b1;
                    ir_valid_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed-plus-random bench for fetch_sequencer; timeout checks run only when FETCH_TIMEOUT_EN is defined.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        halt = 1'b0;
    logic        br_valid = 1'b0;
    logic [11:0] br_addr = '0;
    logic [11:0] ma_addr;
    logic        ma_enable;
    logic        mem_rd_req;
    logic        mem_rd_ack = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic [15:0] ir_out;
    logic        ir_valid;
    logic        ir_ready = 1'b0;
    logic [11:0] pc_out;
    logic        fetch_err;

    int n_cmp = 0;
    int n_err = 0;
    int model_pc = 0;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .halt       (halt),
        .br_valid   (br_valid),
        .br_addr    (br_addr),
        .ma_addr    (ma_addr),
        .ma_enable  (ma_enable),
        .mem_rd_req (mem_rd_req),
        .mem_rd_ack (mem_rd_ack),
        .mem_rdata  (mem_rdata),
        .ir_out     (ir_out),
        .ir_valid   (ir_valid),
        .ir_ready   (ir_ready),
        .pc_out     (pc_out),
        .fetch_err  (fetch_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic junk_ack();
        mem_rd_ack = 1'($urandom_range(0, 1));
        mem_rdata  = 16'($urandom);
    endtask

    // One fetch transaction starting from the cycle the MA strobe is visible.
    // mode: 0 plain handoff, 1 branch together with handoff, 2 branch during back-pressure (no handoff).
    task automatic do_fetch(input int lat, input logic [15:0] data, input int stall,
                            input int mode, input logic [11:0] tgt, input bit hlt);
        chk("addr_strobe", 32'(ma_enable), 1);
        chk("addr_val", 32'(ma_addr), model_pc);
        chk("pc_in_addr", 32'(pc_out), model_pc);
        tick();
        chk("req_rise", 32'(mem_rd_req), 1);
        chk("strobe_fall", 32'(ma_enable), 0);
        for (int i = 0; i <= lat; i++) begin
            if (i > 0) begin
                chk("req_held", 32'(mem_rd_req), 1);
                chk("no_valid_in_req", 32'(ir_valid), 0);
            end
            mem_rd_ack = (i == lat);
            mem_rdata  = (i == lat) ? data : 16'($urandom);
            tick();
        end
        mem_rd_ack = 1'b0;
        chk("req_drop", 32'(mem_rd_req), 0);
        chk("valid_rise", 32'(ir_valid), 1);
        chk("word", 32'(ir_out), 32'(data));
        for (int i = 0; i < stall; i++) begin
            junk_ack();
            ir_ready = 1'b0;
            if (mode == 2 && i == 0) begin
                br_valid = 1'b1;
                br_addr  = tgt;
            end
            tick();
            br_valid = 1'b0;
            if (mode == 2 && i == 0) begin
                mem_rd_ack = 1'b0;
                model_pc   = int'(tgt);
                chk("br_hold_drop", 32'(ir_valid), 0);
                chk("br_hold_strobe", 32'(ma_enable), 1);
                chk("br_hold_addr", 32'(ma_addr), model_pc);
                return;
            end
            chk("bp_valid", 32'(ir_valid), 1);
            chk("bp_word", 32'(ir_out), 32'(data));
            chk("bp_no_strobe", 32'(ma_enable), 0);
            chk("bp_pc", 32'(pc_out), model_pc);
        end
        mem_rd_ack = 1'b0;
        ir_ready   = 1'b1;
        halt       = hlt;
        if (mode == 1) begin
            br_valid = 1'b1;
            br_addr  = tgt;
        end
        tick();
        ir_ready = 1'b0;
        br_valid = 1'b0;
        model_pc = (mode == 1) ? int'(tgt) : (model_pc + 1) % 4096;
        chk("handoff_drop", 32'(ir_valid), 0);
        chk("pc_after", 32'(pc_out), model_pc);
        chk("next_strobe", 32'(ma_enable), hlt ? 0 : 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1);
    end

    initial begin
        repeat (2) tick();
        chk("rst_ma_addr", 32'(ma_addr), 0);
        chk("rst_ma_enable", 32'(ma_enable), 0);
        chk("rst_req", 32'(mem_rd_req), 0);
        chk("rst_ir_out", 32'(ir_out), 0);
        chk("rst_ir_valid", 32'(ir_valid), 0);
        chk("rst_pc", 32'(pc_out), 0);
        chk("rst_err", 32'(fetch_err), 0);

        // Basic fetch with single-cycle ack
        reset = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        do_fetch(0, 16'hA5A5, 0, 0, 12'h000, 1'b0);
        chk("pc_after_first", 32'(pc_out), 1);

        // Random latencies, data and back-pressure, then a full 5-cycle stall
        for (int k = 0; k < 6; k++) begin
            do_fetch(int'($urandom_range(0, 3)), 16'($urandom), int'($urandom_range(0, 4)), 0, 12'h000, 1'b0);
        end
        do_fetch(1, 16'($urandom), 5, 0, 12'h000, 1'b0);

        // Branch in ADDR to just below the wrap point
        br_valid = 1'b1;
        br_addr  = 12'hFFE;
        tick();
        br_valid = 1'b0;
        model_pc = 'hFFE;
        for (int k = 0; k < 3; k++) begin
            do_fetch(int'($urandom_range(0, 2)), 16'($urandom), 0, 0, 12'h000, 1'b0);
        end
        chk("wrap_pc", 32'(pc_out), 1);

        // Branch while awaiting ack: the late word must be dropped
        tick();
        br_valid = 1'b1;
        br_addr  = 12'h123;
        tick();
        br_valid = 1'b0;
        chk("brq_pc", 32'(pc_out), 'h123);
        chk("brq_req_held", 32'(mem_rd_req), 1);
        tick();
        chk("brq_no_valid", 32'(ir_valid), 0);
        mem_rd_ack = 1'b1;
        mem_rdata  = 16'hDEAD;
        tick();
        mem_rd_ack = 1'b0;
        model_pc   = 'h123;
        chk("brq_dropped", 32'(ir_valid), 0);
        chk("brq_req_drop", 32'(mem_rd_req), 0);
        do_fetch(0, 16'h1234, 1, 1, 12'h040, 1'b0);

        // Branch in HOLD without ready, then resume at the target
        do_fetch(2, 16'h5A5A, 2, 2, 12'h0A0, 1'b0);
        do_fetch(1, 16'($urandom), 0, 0, 12'h000, 1'b0);

        // Halt at handoff; halt and branches are honoured/ignored in IDLE as appropriate
        do_fetch(0, 16'($urandom), 0, 0, 12'h000, 1'b1);
        start    = 1'b1;
        br_valid = 1'b1;
        br_addr  = 12'h777;
        junk_ack();
        tick();
        br_valid = 1'b0;
        chk("idle_no_strobe", 32'(ma_enable), 0);
        chk("idle_no_req", 32'(mem_rd_req), 0);
        chk("idle_pc", 32'(pc_out), model_pc);
        chk("idle_no_valid", 32'(ir_valid), 0);
        halt       = 1'b0;
        mem_rd_ack = 1'b0;
        tick();
        start = 1'b0;
        do_fetch(0, 16'($urandom), 0, 0, 12'h000, 1'b0);

`ifdef FETCH_TIMEOUT_EN
        begin
            int n;
            n = 0;
            tick();
            while (mem_rd_req === 1'b1 && n < 40) begin
                n++;
                tick();
            end
            chk("to_req_cycles", n, 15);
            chk("to_err", 32'(fetch_err), 1);
            chk("to_no_strobe", 32'(ma_enable), 0);
            start = 1'b1;
            tick();
            start = 1'b0;
            do_fetch(0, 16'($urandom), 0, 0, 12'h000, 1'b0);
            chk("to_err_sticky", 32'(fetch_err), 1);
        end
`endif

        // Asynchronous reset in the middle of a REQ cycle
        tick();
        chk("pre_rst_req", 32'(mem_rd_req), 1);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_req", 32'(mem_rd_req), 0);
        chk("arst_pc", 32'(pc_out), 0);
        chk("arst_ma_addr", 32'(ma_addr), 0);
        chk("arst_valid", 32'(ir_valid), 0);
        chk("arst_err", 32'(fetch_err), 0);
        tick();
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
